layer_sequencer: RTL and testbench
==================================

# layer_sequencer

Per-layer control FSM that drives the `current_state` bus into the line-buffer exchanger and the PE array. For each output row pass it walks the loop nest slide → output-channel group → input-channel group. It issues one compute window per innermost iteration and one `channel_switch` cycle after each window. It then emits the `clear`, `inputbstart` and `Layer_Finish` controls that restart or end the buffer rotation.

## Interface
Parameters:
- ROW_W, 9, width of row count/counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- layer_start  in  1  pulse; starts a layer when idle.
- load_done  in  1  pulse; input buffer initial fill complete.
- win_done  in  1  pulse; PE array finished current window.
- numswitchH_op  in  5  last slide index per row (inclusive).
- NInch_D_PInch_op  in  5  last input-channel-group index (inclusive).
- NOuch_D_POuch_op  in  5  last output-channel-group index (inclusive).
- num_rows_op  in  ROW_W  output rows in layer.
- poolingen_op  in  1  pooling enabled.
- kernelsize_op  in  1  0 = small kernel.
- current_state  out  4  registered FSM state.
- inputbstart  out  1  one-cycle pulse, first LOAD cycle.
- win_req  out  1  one-cycle pulse, first cycle of each COMPUTE visit.
- Layer_Finish  out  1  one-cycle pulse in DONE.
- busy  out  1  state != IDLE.
- row_cnt  out  ROW_W  current row-pass base row.

## Operation
- State encoding: IDLE=0, LOAD=1, CHANNEL_SWITCH=2, CLEAR=3, COMPUTE=4, DONE=5. The values 2 and 3 are fixed by the exchanger's `channel_switch`/`clear` macros.
- IDLE: on layer_start, latch all *_op inputs into shadow registers, zero all counters, and go to LOAD. The block uses only the shadow values until it returns to IDLE.
- LOAD: wait for load_done, then go to COMPUTE.
- COMPUTE: wait for win_done, then go to CHANNEL_SWITCH.
- CHANNEL_SWITCH, exactly one cycle:
  - Advance the counter nest. in_cnt is innermost, then out_cnt, then slide_cnt. Each counter wraps to 0 after reaching its shadowed *_op value.
  - If all three counters were at their maxima, go to CLEAR; otherwise go to COMPUTE.
- CLEAR, exactly one cycle:
  - step = 2 if (poolingen or kernelsize==0), else 1.
  - If row_cnt + step >= num_rows, go to DONE and leave row_cnt unchanged.
  - Otherwise, row_cnt += step and go to COMPUTE.
- DONE: one cycle, then IDLE.
- Windows per row pass = (numswitchH+1)·(NOuch+1)·(NInch+1). This product is never computed; only the counter nest is used.
- Row sum is computed ROW_W+1 bits wide, so there is no wrap.
- Ignored inputs:
  - layer_start outside IDLE.
  - load_done outside LOAD.
  - win_done outside COMPUTE.
- All *_op = 0 is legal: 1 window per row pass.
- num_rows = 0 or 1: one row pass, then DONE.

## Timing
- Reset values: state IDLE, all counters 0, all outputs 0.
- Reset mid-layer: the next cycle is IDLE with all outputs 0; there is no DONE and no Layer_Finish.
- Pulse timing:
  - layer_start at cycle t → current_state=LOAD and inputbstart=1 at t+1.
  - load_done at t → COMPUTE and win_req=1 at t+1.
  - win_done at t → CHANNEL_SWITCH at t+1 → COMPUTE (win_req) or CLEAR at t+2.
  - CLEAR at t → COMPUTE (win_req) or DONE (Layer_Finish) at t+1.
- win_done in the same cycle that win_req is high is accepted; the window takes 1 cycle.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package / define.v holds:
  - state encodings (the existing channel_switch=2 and clear=3, plus the new IDLE, LOAD, COMPUTE, DONE);
  - ROW_W default.
- One sub-module, loop_nest_cnt: three cascaded wrap counters with a single advance input, producing all_max and the counter values. The FSM stays in the top level.

## Test plan
- NInch=0, NOuch=0, numswitchH=2, num_rows=2, pool=0, ks=1; win_done 1 cycle after each win_req → 6 win_req, 6 CHANNEL_SWITCH cycles, 2 CLEAR, row_cnt 0→1, exactly one Layer_Finish, then busy=0.
- NInch=1, NOuch=1, numswitchH=1, num_rows=1 → 8 windows, in_cnt sequence 0,1,0,1… with out_cnt advancing every 2 and slide_cnt every 4, then DONE.
- pool=1, num_rows=5 → row_cnt 0,2,4, 3 row passes; with num_rows=4 → row_cnt 0,2, 2 passes; with ks=0, pool=0 → step 2 as well.
- layer_start pulsed during COMPUTE, and load_done/win_done pulsed in the wrong states → no state change, no extra win_req; change *_op mid-layer → window count unaffected.
- rst low during COMPUTE of the 3rd window → next cycle current_state=0, all outputs 0; a fresh layer_start then runs a full layer correctly.
- All *_op=0, num_rows=0 → LOAD, one COMPUTE, CHANNEL_SWITCH, CLEAR, DONE; Layer_Finish exactly 4 cycles after load_done when win_done returns immediately.

Source files
------------

// File: rtl/layer_sequencer_pkg.sv
// Shared definitions for the layer sequencer: state encodings and default widths.
package layer_sequencer_pkg;

    // Width of the row counter unless overridden at the top level.
    localparam int unsigned RowWDefault = 9;

    // Width of the slide / channel-group loop counters.
    localparam int unsigned CntW = 5;

    // CHANNEL_SWITCH (2) and CLEAR (3) are decoded by the line-buffer exchanger,
    // so these encodings must not move.
    typedef enum logic [3:0] {
        StIdle          = 4'd0,
        StLoad          = 4'd1,
        StChannelSwitch = 4'd2,
        StClear         = 4'd3,
        StCompute       = 4'd4,
        StDone          = 4'd5
    } state_e;

endpackage

// File: rtl/layer_sequencer_loop_nest_cnt.sv
// Three cascaded wrap counters (in -> out -> slide) advanced together by one strobe.
module layer_sequencer_loop_nest_cnt
    import layer_sequencer_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clear_i,
    input  logic            advance_i,
    input  logic [CntW-1:0] in_max_i,
    input  logic [CntW-1:0] out_max_i,
    input  logic [CntW-1:0] slide_max_i,
    output logic [CntW-1:0] in_cnt_o,
    output logic [CntW-1:0] out_cnt_o,
    output logic [CntW-1:0] slide_cnt_o,
    output logic            all_max_o
);

    logic [CntW-1:0] in_cnt_q, in_cnt_d;
    logic [CntW-1:0] out_cnt_q, out_cnt_d;
    logic [CntW-1:0] slide_cnt_q, slide_cnt_d;
    logic            in_wrap, out_wrap, slide_wrap;

    // Next-state of the nest: each level carries into the next only when it wraps.
    always_comb begin
        in_wrap     = (in_cnt_q == in_max_i);
        out_wrap    = (out_cnt_q == out_max_i);
        slide_wrap  = (slide_cnt_q == slide_max_i);
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        slide_cnt_d = slide_cnt_q;
        if (clear_i) begin
            in_cnt_d    = '0;
            out_cnt_d   = '0;
            slide_cnt_d = '0;
        end else if (advance_i) begin
            in_cnt_d = in_wrap ? '0 : in_cnt_q + 1'b1;
            if (in_wrap) begin
                out_cnt_d = out_wrap ? '0 : out_cnt_q + 1'b1;
                if (out_wrap) begin
                    slide_cnt_d = slide_wrap ? '0 : slide_cnt_q + 1'b1;
                end
            end
        end
    end

    // Counter state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            slide_cnt_q <= '0;
        end else begin
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            slide_cnt_q <= slide_cnt_d;
        end
    end

    assign in_cnt_o    = in_cnt_q;
    assign out_cnt_o   = out_cnt_q;
    assign slide_cnt_o = slide_cnt_q;
    assign all_max_o   = in_wrap && out_wrap && slide_wrap;

endmodule

// File: rtl/layer_sequencer.sv
// Per-layer control FSM: walks slide -> out-group -> in-group per row pass and
// drives the exchanger / PE array state bus with registered pulses.
module layer_sequencer
    import layer_sequencer_pkg::*;
#(
    parameter int unsigned ROW_W = RowWDefault
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             layer_start,
    input  logic             load_done,
    input  logic             win_done,
    input  logic [CntW-1:0]  numswitchH_op,
    input  logic [CntW-1:0]  NInch_D_PInch_op,
    input  logic [CntW-1:0]  NOuch_D_POuch_op,
    input  logic [ROW_W-1:0] num_rows_op,
    input  logic             poolingen_op,
    input  logic             kernelsize_op,
    output logic [3:0]       current_state,
    output logic             inputbstart,
    output logic             win_req,
    output logic             Layer_Finish,
    output logic             busy,
    output logic [ROW_W-1:0] row_cnt
);

    state_e          state_q;
    logic [CntW-1:0] slide_max_q, in_max_q, out_max_q;
    logic [ROW_W-1:0] num_rows_q, row_cnt_q;
    logic            pool_q, ks_q;
    logic            inputbstart_q, win_req_q, finish_q, busy_q;

    logic            cnt_clear, cnt_advance, all_max;
    logic [CntW-1:0] in_cnt, out_cnt, slide_cnt;
    logic [1:0]      step;
    logic [ROW_W:0]  row_sum;

    // Row step and the widened row sum used by CLEAR; counter control strobes.
    always_comb begin
        step        = (pool_q || !ks_q) ? 2'd2 : 2'd1;
        row_sum     = {1'b0, row_cnt_q} + {{(ROW_W - 1){1'b0}}, step};
        cnt_clear   = (state_q == StIdle) && layer_start;
        cnt_advance = (state_q == StChannelSwitch);
    end

    layer_sequencer_loop_nest_cnt u_loop_nest_cnt (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (cnt_clear),
        .advance_i   (cnt_advance),
        .in_max_i    (in_max_q),
        .out_max_i   (out_max_q),
        .slide_max_i (slide_max_q),
        .in_cnt_o    (in_cnt),
        .out_cnt_o   (out_cnt),
        .slide_cnt_o (slide_cnt),
        .all_max_o   (all_max)
    );

    // FSM with shadow registers and registered control pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= StIdle;
            slide_max_q   <= '0;
            in_max_q      <= '0;
            out_max_q     <= '0;
            num_rows_q    <= '0;
            pool_q        <= 1'b0;
            ks_q          <= 1'b0;
            row_cnt_q     <= '0;
            inputbstart_q <= 1'b0;
            win_req_q     <= 1'b0;
            finish_q      <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            inputbstart_q <= 1'b0;
            win_req_q     <= 1'b0;
            finish_q      <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (layer_start) begin
                        slide_max_q   <= numswitchH_op;
                        in_max_q      <= NInch_D_PInch_op;
                        out_max_q     <= NOuch_D_POuch_op;
                        num_rows_q    <= num_rows_op;
                        pool_q        <= poolingen_op;
                        ks_q          <= kernelsize_op;
                        row_cnt_q     <= '0;
                        state_q       <= StLoad;
                        inputbstart_q <= 1'b1;
                        busy_q        <= 1'b1;
                    end
                end
                StLoad: begin
                    if (load_done) begin
                        state_q   <= StCompute;
                        win_req_q <= 1'b1;
                    end
                end
                StCompute: begin
                    if (win_done) begin
                        state_q <= StChannelSwitch;
                    end
                end
                StChannelSwitch: begin
                    // all_max reflects the counters before this cycle's advance.
                    if (all_max) begin
                        state_q <= StClear;
                    end else begin
                        state_q   <= StCompute;
                        win_req_q <= 1'b1;
                    end
                end
                StClear: begin
                    if (row_sum >= {1'b0, num_rows_q}) begin
                        state_q  <= StDone;
                        finish_q <= 1'b1;
                    end else begin
                        row_cnt_q <= row_sum[ROW_W-1:0];
                        state_q   <= StCompute;
                        win_req_q <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign current_state = state_q;
    assign inputbstart   = inputbstart_q;
    assign win_req       = win_req_q;
    assign Layer_Finish  = finish_q;
    assign busy          = busy_q;
    assign row_cnt       = row_cnt_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: expected windows are queued per layer
// and checked against each win_req the DUT issues.
module tb_layer_sequencer;
    import layer_sequencer_pkg::*;

    localparam int unsigned RW = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          layer_start = 1'b0, load_done = 1'b0, win_done = 1'b0;
    logic [4:0]    numswitchH_op = '0, NInch_D_PInch_op = '0, NOuch_D_POuch_op = '0;
    logic [RW-1:0] num_rows_op = '0;
    logic          poolingen_op = 1'b0, kernelsize_op = 1'b0;
    logic [3:0]    current_state;
    logic          inputbstart, win_req, Layer_Finish, busy;
    logic [RW-1:0] row_cnt;

    layer_sequencer #(.ROW_W(RW)) dut (
        .clk              (clk),
        .rst              (rst),
        .layer_start      (layer_start),
        .load_done        (load_done),
        .win_done         (win_done),
        .numswitchH_op    (numswitchH_op),
        .NInch_D_PInch_op (NInch_D_PInch_op),
        .NOuch_D_POuch_op (NOuch_D_POuch_op),
        .num_rows_op      (num_rows_op),
        .poolingen_op     (poolingen_op),
        .kernelsize_op    (kernelsize_op),
        .current_state    (current_state),
        .inputbstart      (inputbstart),
        .win_req          (win_req),
        .Layer_Finish     (Layer_Finish),
        .busy             (busy),
        .row_cnt          (row_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    typedef struct {
        int row;
        int s;
        int o;
        int i;
    } win_t;

    win_t exp_q[$];
    int   cs_cnt, clr_cnt, fin_cnt;

    // Monitor: every win_req consumes one expected window.
    always @(negedge clk) begin
        win_t w;
        if (win_req) begin
            if (exp_q.size() == 0) begin
                check_eq("win_req_extra", int'(win_req), 0);
            end else begin
                w = exp_q.pop_front();
                check_eq("win_row", int'(row_cnt), w.row);
                check_eq("win_slide", int'(dut.slide_cnt), w.s);
                check_eq("win_out", int'(dut.out_cnt), w.o);
                check_eq("win_in", int'(dut.in_cnt), w.i);
            end
        end
        if (current_state == 4'd2) cs_cnt++;
        if (current_state == 4'd3) clr_cnt++;
        if (Layer_Finish) fin_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_layer(input int ns, input int ni, input int no, input int rows,
                               input bit pool, input bit ks,
                               output int wins, output int passes);
        int row;
        int step;
        row    = 0;
        step   = (pool || !ks) ? 2 : 1;
        wins   = 0;
        passes = 0;
        while (1) begin
            passes++;
            for (int s = 0; s <= ns; s++)
                for (int o = 0; o <= no; o++)
                    for (int i = 0; i <= ni; i++) begin
                        exp_q.push_back('{row, s, o, i});
                        wins++;
                    end
            if (row + step >= rows) break;
            row += step;
        end
        cs_cnt           = 0;
        clr_cnt          = 0;
        fin_cnt          = 0;
        numswitchH_op    = 5'(ns);
        NInch_D_PInch_op = 5'(ni);
        NOuch_D_POuch_op = 5'(no);
        num_rows_op      = RW'(rows);
        poolingen_op     = pool;
        kernelsize_op    = ks;
        layer_start      = 1'b1;
        tick();
        layer_start = 1'b0;
        check_eq("start_state", int'(current_state), 1);
        check_eq("start_inputbstart", int'(inputbstart), 1);
        check_eq("start_busy", int'(busy), 1);
        check_eq("start_row", int'(row_cnt), 0);
    endtask

    task automatic do_load();
        tick();
        check_eq("load_hold", int'(current_state), 1);
        check_eq("load_inputbstart_off", int'(inputbstart), 0);
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        check_eq("load_compute", int'(current_state), 4);
        check_eq("load_win_req", int'(win_req), 1);
    endtask

    task automatic finish_run(input int delay, input int wins, input int passes);
        int wait_c;
        wait_c = (current_state == 4'd4 && !win_req) ? 0 : -1;
        for (int c = 0; c < 3000; c++) begin
            win_done = 1'b0;
            if (Layer_Finish) break;
            if (win_req) wait_c = delay;
            if (wait_c == 0) begin
                win_done = 1'b1;
                wait_c   = -1;
            end else if (wait_c > 0) begin
                wait_c--;
            end
            tick();
        end
        win_done = 1'b0;
        check_eq("finish_seen", int'(Layer_Finish), 1);
        check_eq("finish_state", int'(current_state), 5);
        check_eq("finish_busy", int'(busy), 1);
        tick();
        check_eq("idle_state", int'(current_state), 0);
        check_eq("idle_busy", int'(busy), 0);
        check_eq("idle_finish_off", int'(Layer_Finish), 0);
        check_eq("win_missing", exp_q.size(), 0);
        check_eq("cs_cycles", cs_cnt, wins);
        check_eq("clear_cycles", clr_cnt, passes);
        check_eq("finish_pulses", fin_cnt, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_state"}, int'(current_state), 0);
        check_eq({tag, "_inputbstart"}, int'(inputbstart), 0);
        check_eq({tag, "_win_req"}, int'(win_req), 0);
        check_eq({tag, "_finish"}, int'(Layer_Finish), 0);
        check_eq({tag, "_busy"}, int'(busy), 0);
        check_eq({tag, "_row"}, int'(row_cnt), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w, p, wc, wait_c;

        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b1;
        tick();

        // Basic: 3 slides, 2 rows, step 1.
        start_layer(2, 0, 0, 2, 1'b0, 1'b1, w, p);
        do_load();
        finish_run(1, w, p);
        check_eq("a_row_last", int'(row_cnt), 1);

        // Full nest: in/out/slide all 2-deep.
        start_layer(1, 1, 1, 1, 1'b0, 1'b1, w, p);
        do_load();
        finish_run(0, w, p);

        // Step 2 via pooling and via small kernel.
        start_layer(1, 0, 0, 5, 1'b1, 1'b1, w, p);
        do_load();
        finish_run(2, w, p);
        check_eq("pool5_row_last", int'(row_cnt), 4);
        start_layer(0, 0, 0, 4, 1'b1, 1'b1, w, p);
        do_load();
        finish_run(1, w, p);
        check_eq("pool4_row_last", int'(row_cnt), 2);
        start_layer(0, 1, 0, 4, 1'b0, 1'b0, w, p);
        do_load();
        finish_run(0, w, p);
        check_eq("ks0_row_last", int'(row_cnt), 2);

        // Stray pulses in the wrong states and *_op changes mid-layer.
        start_layer(1, 0, 1, 3, 1'b0, 1'b1, w, p);
        win_done = 1'b1;
        tick();
        win_done = 1'b0;
        check_eq("ign_win_done_load", int'(current_state), 1);
        layer_start = 1'b1;
        tick();
        layer_start = 1'b0;
        check_eq("ign_start_load", int'(current_state), 1);
        check_eq("ign_start_inputbstart", int'(inputbstart), 0);
        do_load();
        layer_start      = 1'b1;
        load_done        = 1'b1;
        numswitchH_op    = '0;
        NOuch_D_POuch_op = '0;
        num_rows_op      = RW'(1);
        poolingen_op     = 1'b1;
        tick();
        layer_start = 1'b0;
        load_done   = 1'b0;
        check_eq("ign_compute_state", int'(current_state), 4);
        check_eq("ign_compute_win_req", int'(win_req), 0);
        finish_run(1, w, p);

        // Reset during the third window, then a clean layer.
        start_layer(2, 0, 0, 2, 1'b0, 1'b1, w, p);
        do_load();
        wc     = 0;
        wait_c = -1;
        for (int c = 0; c < 200; c++) begin
            win_done = 1'b0;
            if (win_req) begin
                wc++;
                if (wc == 3) break;
                wait_c = 1;
            end
            if (wait_c == 0) begin
                win_done = 1'b1;
                wait_c   = -1;
            end else if (wait_c > 0) begin
                wait_c--;
            end
            tick();
        end
        win_done = 1'b0;
        check_eq("rst_mid_in_compute", int'(current_state), 4);
        rst = 1'b0;
        tick();
        check_all_zero("rst_mid");
        rst = 1'b1;
        exp_q.delete();
        fin_cnt = 0;
        tick();
        check_eq("rst_mid_no_finish", fin_cnt, 0);
        start_layer(1, 1, 0, 3, 1'b0, 1'b1, w, p);
        do_load();
        finish_run(1, w, p);

        // Minimal layer: Layer_Finish four cycles after load_done.
        start_layer(0, 0, 0, 0, 1'b0, 1'b1, w, p);
        tick();
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        check_eq("min_compute", int'(current_state), 4);
        check_eq("min_win_req", int'(win_req), 1);
        win_done = 1'b1;
        tick();
        win_done = 1'b0;
        check_eq("min_cs", int'(current_state), 2);
        tick();
        check_eq("min_clear", int'(current_state), 3);
        tick();
        check_eq("min_done", int'(current_state), 5);
        check_eq("min_finish", int'(Layer_Finish), 1);
        tick();
        check_eq("min_idle", int'(current_state), 0);
        check_eq("min_busy", int'(busy), 0);
        check_eq("min_win_missing", exp_q.size(), 0);
        check_eq("min_cs_cycles", cs_cnt, w);
        check_eq("min_clear_cycles", clr_cnt, p);
        check_eq("min_finish_pulses", fin_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
